// File: rtl/dsp_cic_comp_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dsp_cic_comp_pkg
//  Purpose : Shared definitions for the CIC droop compensation FIR:
//            FSM state encoding, default tap count, coefficient ROM and a
//            constant-evaluable ceil(log2) helper.
//  Ports   : none (package)
//  Options : none here. The optional saturation feature is controlled by
//            DSP_CIC_COMP_SAT_EN in the design files.
//  Revision: 1.0  initial release
// ============================================================================
package dsp_cic_comp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int DEF_TAPS = 15;
  localparam int COEF_W   = 16;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Symmetric inverse-sinc style response, Q1.15. The DC gain (sum of
  // all taps) is 37456/32768, slightly above unity, which lifts the band
  // edge to cancel CIC droop. c[0] = 128 makes 128 * 128 land exactly on a
  // half-LSB after scaling, which is useful for exercising the rounding path.
  function automatic logic signed [COEF_W-1:0] coef(input int k);
    case (k)
      0, 14:   coef =  16'sd128;
      1, 13:   coef = -16'sd300;
      2, 12:   coef =  16'sd600;
      3, 11:   coef = -16'sd1100;
      4, 10:   coef =  16'sd1900;
      5, 9:    coef = -16'sd3500;
      6, 8:    coef =  16'sd9000;
      7:       coef =  16'sd24000;
      default: coef =  '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_round_sat.sv
`default_nettype none
// ============================================================================
//  Module  : dsp_round_sat
//  Purpose : Combinational reduction of a wide signed accumulator to an
//            output sample: arithmetic shift right by CW-1, optional
//            round-half-away-from-zero, then wrap or clamp to COUT bits.
//  Ports   : acc    [ACCW] in  - signed accumulator value
//            result [COUT] out - reduced sample
//            sat           out - clamping occurred (DSP_CIC_COMP_SAT_EN only)
//  Options : DSP_CIC_COMP_SAT_EN defined  -> clamp to the COUT range
//            DSP_CIC_COMP_SAT_EN undefined -> keep the COUT LSBs (wrap)
//  Revision: 1.0  initial release
// ============================================================================
module dsp_round_sat #(
  parameter int    ACCW       = 36,
  parameter int    CW         = 16,
  parameter int    COUT       = 16,
  parameter string CUT_METHOD = "ROUND"
) (
  input  logic signed [ACCW-1:0] acc,
  output logic signed [COUT-1:0] result
`ifdef DSP_CIC_COMP_SAT_EN
  ,
  output logic                   sat
`endif
);

  localparam int SH       = CW - 1;
  // One guard bit above the shifted width absorbs the rounding carry.
  localparam int SW       = ACCW - SH + 1;
  localparam bit DO_ROUND = (CUT_METHOD == "ROUND");
  localparam logic [SH-1:0] HALF = {1'b1, {(SH-1){1'b0}}};

  logic signed [SW-1:0] floor_v;
  logic signed [SW-1:0] rounded;
  logic        [SH-1:0] frac;
  logic                 carry;

  assign floor_v = SW'(acc >>> SH);
  assign frac    = acc[SH-1:0];

  // floor() already moves negative values toward -inf, so a negative tie is
  // already "away from zero"; only a strictly larger fraction carries.
  assign carry   = DO_ROUND && (acc[ACCW-1] ? (frac > HALF) : (frac >= HALF));
  assign rounded = floor_v + {{(SW-1){1'b0}}, carry};

`ifdef DSP_CIC_COMP_SAT_EN
  logic [SW-COUT:0] hi;
  logic             ovf;

  // In range exactly when every bit from the output sign bit upward agrees.
  assign hi     = rounded[SW-1:COUT-1];
  assign ovf    = !((&hi) || (~|hi));
  assign result = ovf ? {rounded[SW-1], {(COUT-1){~rounded[SW-1]}}}
                      : rounded[COUT-1:0];
  assign sat    = ovf;
`else
  logic unused_hi;

  assign result    = rounded[COUT-1:0];
  assign unused_hi = ^rounded[SW-1:COUT];
`endif

endmodule
`default_nettype wire

// File: rtl/dsp_cic_comp_fir.sv
`default_nettype none
// ============================================================================
//  Module  : dsp_cic_comp_fir
//  Purpose : Serial-MAC CIC droop compensation FIR. One sample is accepted
//            per pass; the single multiplier walks the TAPS coefficients one
//            per clock, then the accumulator is scaled and registered out.
//  Ports   : clk, rst_n        - clock, asynchronous active-low reset
//            din [BIN], din_vld - decimated input sample and strobe
//            dout [COUT], dout_vld - filtered sample and strobe
//            busy               - a MAC pass (or its output cycle) is running
//            drop               - sticky: an input strobe arrived while busy
//            sat_flag           - clamping occurred (DSP_CIC_COMP_SAT_EN only)
//  Options : DSP_CIC_COMP_SAT_EN - clamp instead of wrap, adds sat_flag port
//  Revision: 1.0  initial release
// ============================================================================
module dsp_cic_comp_fir
  import dsp_cic_comp_pkg::*;
#(
  parameter int    BIN        = 16,
  parameter int    COUT       = 16,
  parameter int    CW         = COEF_W,
  parameter int    TAPS       = DEF_TAPS,
  parameter int    ACCW       = BIN + CW + clog2(TAPS),
  parameter string CUT_METHOD = "ROUND"
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [BIN-1:0]  din,
  input  logic                   din_vld,
  output logic signed [COUT-1:0] dout,
  output logic                   dout_vld,
  output logic                   busy,
  output logic                   drop
`ifdef DSP_CIC_COMP_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam int PW = (clog2(TAPS) > 0) ? clog2(TAPS) : 1;
  localparam logic [PW-1:0] LAST = PW'(TAPS - 1);

  state_t                 state;
  state_t                 state_nx;
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          k;
  logic signed [BIN-1:0]  samples [TAPS];
  logic signed [ACCW-1:0] acc;
  logic signed [CW-1:0]   coef_k;
  logic signed [CW+BIN-1:0] prod;
  logic signed [COUT-1:0] reduced;
  logic                   last_tap;

  assign coef_k   = CW'(coef(int'(k)));
  assign prod     = coef_k * samples[rd_ptr];
  assign last_tap = (k == LAST);
  assign busy     = (state != ST_IDLE);

`ifdef DSP_CIC_COMP_SAT_EN
  logic sat_now;
`endif

  dsp_round_sat #(
    .ACCW       (ACCW),
    .CW         (CW),
    .COUT       (COUT),
    .CUT_METHOD (CUT_METHOD)
  ) u_round_sat (
    .acc    (acc),
    .result (reduced)
`ifdef DSP_CIC_COMP_SAT_EN
    ,
    .sat    (sat_now)
`endif
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (din_vld)  state_nx = ST_MAC;
      ST_MAC:  if (last_tap) state_nx = ST_OUT;
      ST_OUT:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      k        <= '0;
      acc      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      drop     <= 1'b0;
`ifdef DSP_CIC_COMP_SAT_EN
      sat_flag <= 1'b0;
`endif
      for (int i = 0; i < TAPS; i++) begin
        samples[i] <= '0;
      end
    end else begin
      dout_vld <= 1'b0;
`ifdef DSP_CIC_COMP_SAT_EN
      sat_flag <= 1'b0;
`endif
      // Only IDLE accepts; a strobe in MAC or OUT is lost and flagged.
      if (din_vld && (state != ST_IDLE)) begin
        drop <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (din_vld) begin
            samples[wr_ptr] <= din;
            acc             <= '0;
            rd_ptr          <= wr_ptr;
            k               <= '0;
          end
        end
        ST_MAC: begin
          acc    <= acc + ACCW'(prod);
          k      <= k + 1'b1;
          // Walk backwards in time: newest sample pairs with coef[0].
          rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
        end
        ST_OUT: begin
          dout     <= reduced;
          dout_vld <= 1'b1;
`ifdef DSP_CIC_COMP_SAT_EN
          sat_flag <= sat_now;
`endif
          wr_ptr   <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_cic_comp_fir.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dsp_cic_comp_fir
//  Purpose : Self-checking bench for dsp_cic_comp_fir. Two instances (ROUND
//            and CUT) share one stimulus stream; a sample-history model
//            predicts every output strobe, value, busy and drop level.
//  Options : DSP_CIC_COMP_SAT_EN selects the clamping expectations.
//  Revision: 1.0  initial release
// ============================================================================
module tb_dsp_cic_comp_fir;

  localparam int TAPS = 15;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic signed [15:0] din = '0;
  logic               din_vld = 1'b0;

  logic signed [15:0] dout_r, dout_c;
  logic               vld_r, vld_c, busy_r, busy_c, drop_r, drop_c;
`ifdef DSP_CIC_COMP_SAT_EN
  logic               sat_r, sat_c;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsp_cic_comp_fir #(.CUT_METHOD("ROUND")) dut_r (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .dout(dout_r), .dout_vld(vld_r), .busy(busy_r), .drop(drop_r)
`ifdef DSP_CIC_COMP_SAT_EN
    , .sat_flag(sat_r)
`endif
  );

  dsp_cic_comp_fir #(.CUT_METHOD("CUT")) dut_c (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .dout(dout_c), .dout_vld(vld_c), .busy(busy_c), .drop(drop_c)
`ifdef DSP_CIC_COMP_SAT_EN
    , .sat_flag(sat_c)
`endif
  );

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  int coef_tab [TAPS] = '{128, -300, 600, -1100, 1900, -3500, 9000, 24000,
                          9000, -3500, 1900, -1100, 600, -300, 128};

  // Scale by 2^-15, round half away from zero (rnd) or floor, then fit 16 bits.
  function automatic longint reduce(input longint a, input bit rnd, output bit sat);
    longint s, mag;
    if (rnd) begin
      mag = (a < 0) ? -a : a;
      s   = (mag + 16384) / 32768;
      if (a < 0) s = -s;
    end else begin
      s = a >>> 15;
    end
    sat = 1'b0;
`ifdef DSP_CIC_COMP_SAT_EN
    if (s > 32767)  begin s = 32767;  sat = 1'b1; end
    if (s < -32768) begin s = -32768; sat = 1'b1; end
`else
    s = longint'(shortint'(s));
`endif
    return s;
  endfunction

  int     hist [$];
  longint m_edge = 0, m_last = 0, m_due = 0;
  bit     m_have = 0, m_pending = 0, m_drop = 0;
  longint m_val_r = 0, m_val_c = 0;
  bit     m_sat_r = 0, m_sat_c = 0;

  always @(posedge clk or negedge rst_n) begin
    longint a;
    if (!rst_n) begin
      m_edge = 0; m_have = 0; m_pending = 0; m_drop = 0;
      hist.delete();
    end else begin
      m_edge++;
      if (din_vld) begin
        // A new pass needs TAPS+2 clocks since the previous acceptance.
        if (!m_have || (m_edge - m_last) >= TAPS + 2) begin
          m_have = 1; m_last = m_edge;
          hist.push_front(int'(din));
          if (hist.size() > TAPS) void'(hist.pop_back());
          a = 0;
          for (int j = 0; j < hist.size(); j++) a += longint'(coef_tab[j]) * hist[j];
          m_val_r   = reduce(a, 1'b1, m_sat_r);
          m_val_c   = reduce(a, 1'b0, m_sat_c);
          m_pending = 1;
          m_due     = m_edge + TAPS + 1;
        end else begin
          m_drop = 1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Compare every cycle
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    bit ev, eb;
    if (!rst_n) begin
      check("rst_dout_r", dout_r, 0);   check("rst_dout_c", dout_c, 0);
      check("rst_vld_r", vld_r, 0);     check("rst_vld_c", vld_c, 0);
      check("rst_busy_r", busy_r, 0);   check("rst_busy_c", busy_c, 0);
      check("rst_drop_r", drop_r, 0);   check("rst_drop_c", drop_c, 0);
    end else begin
      ev = m_pending && (m_edge == m_due);
      eb = m_have && ((m_edge - m_last) <= TAPS);
      check("dout_vld_r", vld_r, ev);   check("dout_vld_c", vld_c, ev);
      check("busy_r", busy_r, eb);      check("busy_c", busy_c, eb);
      check("drop_r", drop_r, m_drop);  check("drop_c", drop_c, m_drop);
      if (ev) begin
        check("dout_r", dout_r, m_val_r);
        check("dout_c", dout_c, m_val_c);
`ifdef DSP_CIC_COMP_SAT_EN
        check("sat_r", sat_r, m_sat_r);
        check("sat_c", sat_c, m_sat_c);
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  longint last_r, last_c;
  bit     last_sat;

  task automatic do_reset();
    din_vld = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse(input int x);
    @(posedge clk); #1 din = 16'(x); din_vld = 1'b1;
    @(posedge clk); #1 din_vld = 1'b0;
  endtask

  // Send one sample, wait (bounded) for its output, optionally pin literals.
  task automatic send_and_check(input int x, input bit chk, input int lr,
                                input int lc, input string nm);
    bit got;
    got = 0;
    pulse(x);
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (vld_r) begin
        got = 1; last_r = dout_r; last_c = dout_c;
`ifdef DSP_CIC_COMP_SAT_EN
        last_sat = sat_r;
`else
        last_sat = 1'b0;
`endif
      end
    end
    if (chk) begin
      check({nm, "_seen"}, longint'(got), 1);
      check({nm, "_round"}, last_r, lr);
      check({nm, "_cut"}, last_c, lc);
    end
  endtask

  int imp_exp [16] = '{64, -150, 300, -550, 950, -1750, 4500, 12000,
                       4500, -1750, 950, -550, 300, -150, 64, 0};

  initial begin
    int nout;
    longint first_r, first_c;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Impulse: outputs trace c[k]/2
    for (int i = 0; i < 16; i++)
      send_and_check((i == 0) ? 16384 : 0, 1'b1, imp_exp[i], imp_exp[i], "impulse");

    // DC: steady state round(1000 * 37456 / 32768) = 1143
    do_reset();
    for (int i = 0; i < 3 * TAPS; i++)
      send_and_check(1000, (i == 3 * TAPS - 1), 1143, 1143, "dc");

    // Back-to-back violation
    do_reset();
    pulse(5000);
    repeat (4) @(posedge clk);
    #1 din = -16'sd7000; din_vld = 1'b1;
    @(posedge clk); #1 din_vld = 1'b0;
    nout = 0; first_r = 0; first_c = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (vld_r) begin nout++; first_r = dout_r; first_c = dout_c; end
    end
    check("b2b_count", nout, 1);
    check("b2b_round", first_r, 20);
    check("b2b_cut", first_c, 19);
    check("b2b_drop", drop_r, 1);
    // Only 5000 is in history: round/floor(5000 * -300 / 32768) = -46
    send_and_check(0, 1'b1, -46, -46, "b2b_hist");
    check("b2b_drop_sticky", drop_r, 1);

    // Overflow: 32767 * 37456 / 32768 = 37454.86
    do_reset();
    for (int i = 0; i < 20; i++) begin
`ifdef DSP_CIC_COMP_SAT_EN
      send_and_check(32767, (i == 19), 32767, 32767, "ovf");
`else
      send_and_check(32767, (i == 19), -28081, -28082, "ovf");
`endif
    end
`ifdef DSP_CIC_COMP_SAT_EN
    check("ovf_sat_flag", last_sat, 1);
`endif

    // Rounding ties: 128 * (+/-128) = +/-0.5 LSB
    do_reset();
    send_and_check(128, 1'b1, 1, 0, "tie_pos");
    do_reset();
    send_and_check(-128, 1'b1, -1, -1, "tie_neg");

    // Reset in the middle of the MAC pass
    do_reset();
    pulse(20000);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    nout = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (vld_r) nout++;
    end
    check("abort_no_vld", nout, 0);
    // Zero history: 128 * 10000 / 32768 = 39.06
    send_and_check(10000, 1'b1, 39, 39, "after_abort");

    // Random samples with random spacing (some too close, causing drops)
    do_reset();
    for (int i = 0; i < 150; i++) begin
      int x;
      x = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 9) == 0) x = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
      pulse(x);
      repeat ($urandom_range(1, 30)) @(posedge clk);
    end
    repeat (30) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
